// File: rtl/viterbi_pack_ctrl.sv
// Frame controller for the decoder output bit packer.
// Admits one frame of bits, zero-pads the last byte and tags it.
module viterbi_pack_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_bits,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-3:0] byte_cnt,
  input  logic             in_bit_valid,
  input  logic             in_bit,
  output logic             in_bit_ready,
  output logic             pk_rst,
  output logic             pk_bit_valid,
  output logic             pk_bit,
  input  logic             pk_out_valid,
  input  logic [7:0]       pk_out_byte,
  output logic             pk_out_ready,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  output logic             out_last,
  input  logic             out_ready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLR    = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] PAD    = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [2:0]       idx_q, idx_d;
  logic             hold_q, hold_d;
  logic [LEN_W-3:0] cnt_q, cnt_d;
  logic             pk_rst_q, pk_rst_d;
  logic             hs;

  assign hs           = pk_out_valid && out_ready;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign byte_cnt     = cnt_q;
  assign pk_rst       = pk_rst_q;
  assign pk_out_ready = out_ready;
  assign out_valid    = pk_out_valid;
  assign out_byte     = pk_out_byte;
  assign out_last     = pk_out_valid && (state_q == DRAIN);

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    pk_rst_d     = 1'b0;
    in_bit_ready = 1'b0;
    pk_bit_valid = 1'b0;
    pk_bit       = 1'b0;
    if (hs && state_q != IDLE) begin
      hold_d = 1'b0;
      cnt_d  = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = frame_bits;
          cnt_d   = '0;
          idx_d   = '0;
          hold_d  = 1'b0;
          state_d = CLR;
        end
      end
      CLR: state_d = (rem_q == '0) ? DONE : STREAM;
      STREAM: begin
        in_bit_ready = !hold_q;
        if (in_bit_valid && !hold_q) begin
          pk_bit_valid = 1'b1;
          pk_bit       = in_bit;
          rem_d        = rem_q - 1'b1;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'd7) hold_d = 1'b1;
          if (rem_q == LEN_W'(1))
            state_d = (idx_q == 3'd7) ? DRAIN : PAD;
        end
      end
      PAD: begin
        if (!hold_q) begin
          pk_bit_valid = 1'b1;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            hold_d  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   if (hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == CLR) pk_rst_d = 1'b1;
    // Abort drops the frame; the packer is flushed on the way out.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = cnt_q;
      pk_rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      hold_q   <= 1'b0;
      cnt_q    <= '0;
      pk_rst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      pk_rst_q <= pk_rst_d;
    end
  end

endmodule

// File: tb/tb_viterbi_pack_ctrl.sv
// Bench for viterbi_pack_ctrl with a behavioural 8-bit packer.
// Frame vectors from a table, plus abort and async-reset sequences.
module tb_viterbi_pack_ctrl;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] frame_bits;
  logic             abort;
  logic             busy;
  logic             done;
  logic [LEN_W-3:0] byte_cnt;
  logic             in_bit_valid;
  logic             in_bit;
  logic             in_bit_ready;
  logic             pk_rst;
  logic             pk_bit_valid;
  logic             pk_bit;
  logic             pk_out_valid;
  logic [7:0]       pk_out_byte;
  logic             pk_out_ready;
  logic             out_valid;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             out_ready;

  always #5 clk = ~clk;

  viterbi_pack_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_bits(frame_bits), .abort(abort),
    .busy(busy), .done(done), .byte_cnt(byte_cnt),
    .in_bit_valid(in_bit_valid), .in_bit(in_bit),
    .in_bit_ready(in_bit_ready), .pk_rst(pk_rst),
    .pk_bit_valid(pk_bit_valid), .pk_bit(pk_bit),
    .pk_out_valid(pk_out_valid), .pk_out_byte(pk_out_byte),
    .pk_out_ready(pk_out_ready), .out_valid(out_valid),
    .out_byte(out_byte), .out_last(out_last),
    .out_ready(out_ready)
  );

  // Packer: LSB-first, byte visible the cycle after the 8th bit.
  logic [2:0] m_cnt;
  logic [6:0] m_sr;
  logic       m_pv;
  logic [7:0] m_pb;
  logic       m_ovf = 1'b0;

  assign pk_out_valid = m_pv;
  assign pk_out_byte  = m_pb;

  always @(posedge clk) begin
    if (pk_rst) begin
      m_cnt <= '0;
      m_sr  <= '0;
      m_pv  <= 1'b0;
      m_pb  <= '0;
    end else begin
      if (m_pv && pk_out_ready) m_pv <= 1'b0;
      if (pk_bit_valid) begin
        if (m_pv) m_ovf <= 1'b1;
        if (m_cnt == 3'd7) begin
          m_pv  <= 1'b1;
          m_pb  <= {pk_bit, m_sr};
          m_cnt <= '0;
        end else begin
          m_sr[m_cnt] <= pk_bit;
          m_cnt       <= m_cnt + 3'd1;
        end
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int          bits;
    logic [31:0] data;
    int          stall;
    int          nbytes;
    logic [23:0] exp;
    int          pads;
  } vec_t;

  vec_t vt[5];

  task automatic run_frame(input int id, input vec_t v);
    int idx, cyc, npad, first, hs_cyc, done_cyc;
    logic [7:0] held;
    bit stall_bad, pad_bad;
    logic [7:0] bytes[$];
    logic lasts[$];
    string p;
    p = $sformatf("frame%0d", id);
    @(negedge clk);
    frame_bits = v.bits[LEN_W-1:0];
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({p, " busy in CLR"}, 32'(busy), 1);
    chk({p, " pk_rst in CLR"}, 32'(pk_rst), 1);
    idx = 0; cyc = 0; npad = 0; first = -1;
    hs_cyc = -1; done_cyc = -1;
    held = '0; stall_bad = 0; pad_bad = 0;
    while (done_cyc < 0 && cyc < 400) begin
      in_bit_valid = (idx < v.bits);
      in_bit = (idx < 32) ? v.data[idx] : 1'b0;
      out_ready = !(first >= 0 && cyc < first + v.stall);
      #1;
      if (out_valid && first < 0) begin
        first = cyc;
        held = out_byte;
        out_ready = (v.stall == 0);
        #1;
      end
      if (first >= 0 && cyc < first + v.stall)
        if (in_bit_ready || !out_valid || out_byte !== held)
          stall_bad = 1;
      if (done) done_cyc = cyc;
      if (in_bit_valid && in_bit_ready) idx++;
      else if (pk_bit_valid) begin
        npad++;
        if (pk_bit) pad_bad = 1;
      end
      if (out_valid && out_ready) begin
        bytes.push_back(out_byte);
        lasts.push_back(out_last);
        hs_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_bit_valid = 1'b0;
    out_ready = 1'b1;
    chk({p, " done seen"}, 32'(done_cyc >= 0), 1);
    chk({p, " busy after done"}, 32'(busy), 0);
    chk({p, " bits consumed"}, 32'(idx), 32'(v.bits));
    chk({p, " byte count"}, 32'(bytes.size()), 32'(v.nbytes));
    for (int i = 0; i < v.nbytes && i < bytes.size(); i++) begin
      chk($sformatf("%s byte%0d", p, i), 32'(bytes[i]),
          32'(v.exp[8*i +: 8]));
      chk($sformatf("%s last%0d", p, i), 32'(lasts[i]),
          32'(i == v.nbytes - 1));
    end
    chk({p, " pad pushes"}, 32'(npad), 32'(v.pads));
    chk({p, " pad bits zero"}, 32'(pad_bad), 0);
    chk({p, " byte_cnt"}, 32'(byte_cnt), 32'(v.nbytes));
    if (v.nbytes == 0) chk({p, " done latency"}, 32'(done_cyc), 1);
    else chk({p, " done after last hs"}, 32'(done_cyc), 32'(hs_cyc + 1));
    if (v.stall > 0) chk({p, " stall hold"}, 32'(stall_bad), 0);
  endtask

  task automatic feed_bits(input int n, input logic [15:0] d);
    int k, c;
    k = 0; c = 0;
    while (k < n && c < 40) begin
      in_bit_valid = 1'b1;
      in_bit = d[k];
      #1;
      if (in_bit_ready) k++;
      @(negedge clk);
      c++;
    end
    chk("feed accepted", 32'(k), 32'(n));
  endtask

  initial begin
    vt[0] = '{16, 32'h34A5,   0, 2, 24'h0034A5, 0};
    vt[1] = '{13, 32'h1A5B,   0, 2, 24'h001A5B, 3};
    vt[2] = '{24, 32'hC37E91, 5, 3, 24'hC37E91, 0};
    vt[3] = '{0,  32'h0,      0, 0, 24'h000000, 0};
    vt[4] = '{3,  32'h5,      0, 1, 24'h000005, 5};

    rst_n = 1'b0; start = 1'b0; frame_bits = '0; abort = 1'b0;
    in_bit_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst in_bit_ready", 32'(in_bit_ready), 0);
    chk("rst pk_bit_valid", 32'(pk_bit_valid), 0);
    chk("rst byte_cnt", 32'(byte_cnt), 0);
    chk("rst pk_rst", 32'(pk_rst), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pk_rst after reset", 32'(pk_rst), 0);

    for (int i = 0; i < 5; i++) run_frame(i, vt[i]);

    // Abort mid-frame, then abort in IDLE is ignored.
    @(negedge clk);
    frame_bits = 16'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    feed_bits(5, 16'h0015);
    in_bit_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort pk_rst", 32'(pk_rst), 1);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort byte_cnt", 32'(byte_cnt), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort pk_rst", 32'(pk_rst), 0);
    chk("idle abort busy", 32'(busy), 0);
    run_frame(5, '{8, 32'h3C, 0, 1, 24'h00003C, 0});

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    frame_bits = 16'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    feed_bits(4, 16'h000A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst in_bit_ready", 32'(in_bit_ready), 0);
    chk("arst pk_bit_valid", 32'(pk_bit_valid), 0);
    chk("arst pk_rst", 32'(pk_rst), 1);
    chk("arst byte_cnt", 32'(byte_cnt), 0);
    in_bit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst pk_rst release", 32'(pk_rst), 0);
    run_frame(6, '{8, 32'hF0, 0, 1, 24'h0000F0, 0});

    chk("no push into full packer", 32'(m_ovf), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/viterbi_pack_ctrl.md
# viterbi_pack_ctrl

Frame-level controller that sequences the decoder output bit packer (`bit_packer_8x`). It sits between the Viterbi traceback bit stream and the packer, and admits exactly one configured frame of decoded bits. It pads a partial final byte with zero bits and tags the final byte with `out_last`. It also owns the packer's clear and forwards the packer's byte handshake downstream.

## Interface

**Parameters**
- `LEN_W`, default 16: width of the frame length in bits. Frame byte count width is `LEN_W-2`.

**Ports**
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame start; honoured only in IDLE.
- `frame_bits`  in  LEN_W  frame length in bits; sampled when `start` is accepted.
- `abort`  in  1  one-cycle abort of the current frame.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the frame completes.
- `byte_cnt`  out  LEN_W-2  bytes handed off downstream in the current or last frame.
- `in_bit_valid`, `in_bit`  in  1, 1  decoded bit stream from traceback.
- `in_bit_ready`  out  1  bit accepted when valid and ready.
- `pk_rst`  out  1  registered synchronous clear to the packer (active-high).
- `pk_bit_valid`, `pk_bit`  out  1, 1  bit push into the packer.
- `pk_out_valid`, `pk_out_byte`  in  1, 8  byte from the packer.
- `pk_out_ready`  out  1  equals `out_ready`.
- `out_valid`, `out_byte`  out  1, 8  equal `pk_out_valid` and `pk_out_byte`.
- `out_last`  out  1  high while `out_valid` and state is DRAIN.
- `out_ready`  in  1  downstream ready.

## Operation

**States:** IDLE, CLR, STREAM, PAD, DRAIN, DONE.

**Transitions**
- IDLE: `start` latches `frame_bits` into `rem`, clears `byte_cnt`, `bit_idx` and `hold`, and goes to CLR.
- CLR: `pk_rst` is 1 for this one cycle. Go to DONE if `rem == 0`, else to STREAM.
- STREAM: `in_bit_ready = !hold`. On each accepted bit:
  - `pk_bit_valid = 1` and `pk_bit = in_bit`, combinationally in the same cycle.
  - `rem` decrements and `bit_idx` (3-bit) increments.
  - When `bit_idx` wraps 7→0, set `hold`.
  - When the accepted bit makes `rem` reach 0: go to DRAIN if the new `bit_idx == 0`, else to PAD.
- PAD: while `!hold`, push a zero bit every cycle (`pk_bit_valid = 1`, `pk_bit = 0`). When `bit_idx` wraps, set `hold` and go to DRAIN. The pad count is `8 - bit_idx`.
- DRAIN: wait for the final byte handshake (`pk_out_valid && out_ready`), then go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.

**Byte slot rule**
- `hold` clears on any `pk_out_valid && out_ready` handshake.
- No bit is pushed while `hold` is set. The packer therefore never receives a bit while a completed byte is still unaccepted.
- `byte_cnt` increments on every handshake.

**Abort**
- `abort` in any non-IDLE state goes to IDLE. `pk_rst` is registered 1 in the following cycle. No `done`; `byte_cnt` holds.
- `abort` has priority over `start` in the same cycle.
- `abort` in IDLE is ignored.

**Other rules**
- `start` while `busy` is ignored.
- `frame_bits = 0`: CLR → DONE. No bits and no bytes are produced.
- `ceil(frame_bits/8)` bytes are produced per frame. The unused high bits of the final byte are 0.

## Timing

- **Reset values** (while `rst_n` = 0): state IDLE; `busy`, `done`, `in_bit_ready`, `pk_bit_valid` = 0; `byte_cnt` = 0; `pk_rst` = 1.
- `pk_rst` drops at the first clock edge after `rst_n` deasserts.
- `start` accepted at edge N:
  - `busy` = 1 and `pk_rst` = 1 during cycle N+1 (CLR).
  - `in_bit_ready` can first be 1 in cycle N+2.
- Full throughput in STREAM is one bit per cycle. After each 8th bit there is at least one bubble cycle, because the packer presents the byte one cycle later and `hold` must clear first.
- `out_valid`, `out_byte` and `out_ready` pass through combinationally with zero latency. `out_byte` stays stable while `out_valid && !out_ready`, as the packer guarantees.
- `done` is asserted in the cycle after the final handshake edge. `busy` falls in the cycle after `done`.
- Reset asserted mid-frame: all state is cleared asynchronously and the packer is held cleared through `pk_rst`. No `done` is produced.

## Test plan

- **Exact frame:** `frame_bits = 16`, bits of 16'h34A5 LSB-first, `out_ready = 1` → bytes 8'hA5 then 8'h34, `out_last` only on 8'h34, `done` one cycle after, `byte_cnt = 2`.
- **Padded frame:** `frame_bits = 13`, bits of 13'h1A5B LSB-first → bytes 8'h5B then 8'h1A with `out_last`; exactly 3 zero pad pushes seen on `pk_bit_valid`.
- **Backpressure:** 24-bit frame; `out_ready = 0` for 5 cycles after the first byte appears → `in_bit_ready = 0` and `out_byte` unchanged throughout; all 3 bytes are correct after release.
- **Zero length:** `frame_bits = 0` → `done` two cycles after `start`, `out_valid` never asserted, `byte_cnt = 0`.
- **Abort:** abort after 5 bits of frame A → `pk_rst` pulses, `busy = 0`, no `done`. Then an 8-bit frame of 8'h3C → single byte 8'h3C with `out_last`.
- **Async reset:** `rst_n` low mid-STREAM → all outputs at their reset values immediately; a following 8-bit frame of 8'hF0 is correct.
